nibble_mayor_acum: RTL and testbench
====================================

Name: nibble_mayor_acum

Overview:
- Downstream stage of the two-input nibble comparator.
- Consumes the stream of winning nibbles, one per valid beat, and tracks the running unsigned maximum over a frame.
- Publishes the frame maximum and beat count through a valid/ready output register with sticky overflow reporting.
- Feeds the frame-level consumer (display/register bank) of the nibble-max datapath.

Parameters:
- FRAME_LEN, 8, maximum beats per frame; the frame is force-closed when the count reaches this value.
- CNT_W, $clog2(FRAME_LEN+1), width of beat counter and count output (derived; do not override).

Ports:
- CLK  input  1  single clock, rising edge.
- RESET_L  input  1  asynchronous active-low reset.
- acum_in  input  4  nibble from comparator (nm2_mayor).
- acum_in_valid  input  1  acum_in valid this cycle; always accepted (no input backpressure).
- acum_in_last  input  1  beat is last of frame; ignored when acum_in_valid=0.
- acum_max  output  4  published frame maximum.
- acum_count  output  CNT_W  beats in published frame.
- acum_trunc  output  1  published frame was force-closed at FRAME_LEN without last.
- acum_valid  output  1  published result pending.
- acum_ready  input  1  consumer accepts result when acum_valid=1.
- acum_overflow  output  1  sticky: unconsumed result was overwritten.
- acum_clr_ovf  input  1  synchronous clear of acum_overflow.

Behaviour:
- Reset (RESET_L=0, asynchronous): state IDLE, running max=0, counter=0; acum_max=0, acum_count=0, acum_trunc=0, acum_valid=0, acum_overflow=0. Mid-frame reset discards the partial frame; no result is published.
- FSM states: IDLE (no open frame), ACUM (frame open).
- IDLE + valid beat: max<=acum_in, cnt<=1. If last (or FRAME_LEN==1), publish and stay in IDLE; else go to ACUM.
- IDLE + no valid beat: hold.
- ACUM + valid beat: compute m=max(max,acum_in) unsigned and c=cnt+1.
  - If last: publish (m, c, trunc=0) and go to IDLE.
  - Else if c==FRAME_LEN: publish (m, c, trunc=1) and go to IDLE.
  - Else: max<=m, cnt<=c.
- ACUM + no valid beat: hold; a frame may span idle gaps indefinitely.
- Equal nibbles: the max is unchanged.
- Publish latency: result registered on the accepting edge; acum_valid=1 the cycle after the closing beat.
- Output handshake: a transfer occurs on an edge with acum_valid & acum_ready. With no publish that cycle, acum_valid<=0. acum_max/count/trunc remain stable while acum_valid=1 and no publish occurs.
- Publish with acum_valid=0, or with acum_valid=1 & acum_ready=1: load the new result, acum_valid<=1, no overflow.
- Publish with acum_valid=1 & acum_ready=0: overwrite with the new result, acum_valid stays 1, acum_overflow<=1.
- acum_overflow clears on acum_clr_ovf. If set and clear occur in the same cycle, set wins.
- Back-to-back frames: a beat in the cycle after a close starts a new frame (IDLE handles it) with no bubble.
- Output acum_max/count/trunc are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro NIBBLE_MAYOR_ACUM_MIN_EN.
- Defined: adds output acum_min [3:0] (reset 0) tracking the unsigned frame minimum. It follows the same update, publish and hold rules as acum_max, including overwrite on overflow.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package nibble_mayor_pkg: NIBBLE_W=4, state encoding IDLE=1'b0 / ACUM=1'b1, and a default FRAME_LEN constant.
- One natural sub-module: nibble_acum_out_reg, the valid/ready output holding register with overflow sticky bit. It is reusable by the other frame-level stages.
- FSM and running max stay in the top module.

Test Plan:
- Reset then frame 3,9,5(last) with acum_ready=1 -> one cycle after the last beat: acum_max=9, acum_count=3, acum_trunc=0, acum_valid=1 for one cycle.
- FRAME_LEN=8, 8 beats of 2,2,...,2,A with no last -> acum_max=A, acum_count=8, acum_trunc=1; a 9th beat 1(last) then gives acum_max=1, acum_count=1.
- Frame F(last) with acum_ready=0, then frame 4(last) -> acum_max=4, acum_valid stays 1, acum_overflow=1. Pulse acum_clr_ovf -> acum_overflow=0.
- Frame 7,gap of 5 idle cycles,E,gap,3(last) -> acum_max=E, acum_count=3; outputs unchanged during gaps.
- RESET_L low mid-frame after beats C,D, then frame 1(last) -> no publish for C/D; result acum_max=1, acum_count=1, all other outputs reset-valued in between.
- With NIBBLE_MAYOR_ACUM_MIN_EN: frame 6,2,B(last) -> acum_max=B, acum_min=2, acum_count=3.

Source files
------------

// File: rtl/nibble_mayor_pkg.sv
// Shared types and constants for the nibble-max datapath.
// Holds the nibble width, the accumulator state encoding and the min/max helpers.
package nibble_mayor_pkg;

  localparam int NIBBLE_W          = 4;
  localparam int DEFAULT_FRAME_LEN = 8;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  typedef enum logic {
    IDLE = 1'b0,
    ACUM = 1'b1
  } acum_state_e;

  function automatic nibble_t nib_max(input nibble_t a, input nibble_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic nibble_t nib_min(input nibble_t a, input nibble_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/nibble_acum_out_reg.sv
// Valid/ready output holding register with a sticky overflow flag.
// A publish while an unconsumed result is pending overwrites it and sets overflow.
module nibble_acum_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              pub,
  input  logic [DATA_W-1:0] pub_data,
  input  logic              ready,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              overflow
);

  logic lost;

  assign lost = pub & valid & ~ready;

  // Payload and valid: a publish always loads; otherwise a transfer drains the slot.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (pub) begin
      data  <= pub_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  // Setting the sticky flag takes priority over a simultaneous clear.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      overflow <= 1'b0;
    end else if (lost) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/nibble_mayor_acum.sv
// Frame accumulator: running unsigned max (and min when NIBBLE_MAYOR_ACUM_MIN_EN
// is defined) of winning nibbles, published through nibble_acum_out_reg.
module nibble_mayor_acum
  import nibble_mayor_pkg::*;
#(
  parameter  int FRAME_LEN = DEFAULT_FRAME_LEN,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                CLK,
  input  logic                RESET_L,
  input  logic [NIBBLE_W-1:0] acum_in,
  input  logic                acum_in_valid,
  input  logic                acum_in_last,
  output logic [NIBBLE_W-1:0] acum_max,
`ifdef NIBBLE_MAYOR_ACUM_MIN_EN
  output logic [NIBBLE_W-1:0] acum_min,
`endif
  output logic [CNT_W-1:0]    acum_count,
  output logic                acum_trunc,
  output logic                acum_valid,
  input  logic                acum_ready,
  output logic                acum_overflow,
  input  logic                acum_clr_ovf
);

`ifdef NIBBLE_MAYOR_ACUM_MIN_EN
  localparam int PAY_W = 1 + CNT_W + 2 * NIBBLE_W;
`else
  localparam int PAY_W = 1 + CNT_W + NIBBLE_W;
`endif

  acum_state_e state, next_state;

  nibble_t          run_max, beat_max;
  logic [CNT_W-1:0] cnt, beat_cnt;
  logic             hit_len, close, trunc;
  logic [PAY_W-1:0] pub_data, out_data;

`ifdef NIBBLE_MAYOR_ACUM_MIN_EN
  nibble_t run_min, beat_min;
`endif

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) state <= IDLE;
    else          state <= next_state;
  end

  // IDLE seeds a fresh frame from the beat; ACUM folds the beat into the running values.
  always_comb begin
    next_state = state;
    beat_max   = acum_in;
    beat_cnt   = CNT_W'(1);
`ifdef NIBBLE_MAYOR_ACUM_MIN_EN
    beat_min   = acum_in;
`endif
    if (state == ACUM) begin
      beat_max = nib_max(run_max, acum_in);
      beat_cnt = cnt + CNT_W'(1);
`ifdef NIBBLE_MAYOR_ACUM_MIN_EN
      beat_min = nib_min(run_min, acum_in);
`endif
    end
    hit_len = (beat_cnt == CNT_W'(FRAME_LEN));
    close   = 1'b0;
    trunc   = 1'b0;
    if (acum_in_valid) begin
      close      = acum_in_last | hit_len;
      trunc      = ~acum_in_last & hit_len;
      next_state = close ? IDLE : ACUM;
    end
  end

  // Running values are cleared on close so an IDLE frame never sees stale state.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      run_max <= '0;
      cnt     <= '0;
    end else if (acum_in_valid) begin
      if (close) begin
        run_max <= '0;
        cnt     <= '0;
      end else begin
        run_max <= beat_max;
        cnt     <= beat_cnt;
      end
    end
  end

`ifdef NIBBLE_MAYOR_ACUM_MIN_EN
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      run_min <= '0;
    end else if (acum_in_valid) begin
      run_min <= close ? '0 : beat_min;
    end
  end

  assign pub_data = {beat_min, trunc, beat_cnt, beat_max};
  assign {acum_min, acum_trunc, acum_count, acum_max} = out_data;
`else
  assign pub_data = {trunc, beat_cnt, beat_max};
  assign {acum_trunc, acum_count, acum_max} = out_data;
`endif

  nibble_acum_out_reg #(
    .DATA_W (PAY_W)
  ) u_out_reg (
    .CLK      (CLK),
    .RESET_L  (RESET_L),
    .pub      (close),
    .pub_data (pub_data),
    .ready    (acum_ready),
    .clr_ovf  (acum_clr_ovf),
    .data     (out_data),
    .valid    (acum_valid),
    .overflow (acum_overflow)
  );

endmodule

// File: tb/tb_nibble_mayor_acum.sv
// Directed scoreboard bench for nibble_mayor_acum; min output checked when
// NIBBLE_MAYOR_ACUM_MIN_EN is defined.
module tb_nibble_mayor_acum;

  localparam int CNT_W = 4;

  typedef struct {
    logic [3:0] max;
    logic [3:0] cnt;
    logic       trunc;
    logic [3:0] min;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RESET_L = 1'b0;
  logic [3:0]       acum_in = '0;
  logic             acum_in_valid = 1'b0;
  logic             acum_in_last = 1'b0;
  logic [3:0]       acum_max;
  logic [CNT_W-1:0] acum_count;
  logic             acum_trunc;
  logic             acum_valid;
  logic             acum_ready = 1'b1;
  logic             acum_overflow;
  logic             acum_clr_ovf = 1'b0;
`ifdef NIBBLE_MAYOR_ACUM_MIN_EN
  logic [3:0]       acum_min;
`endif

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  nibble_mayor_acum #(.FRAME_LEN(8)) dut (
    .CLK           (CLK),
    .RESET_L       (RESET_L),
    .acum_in       (acum_in),
    .acum_in_valid (acum_in_valid),
    .acum_in_last  (acum_in_last),
    .acum_max      (acum_max),
`ifdef NIBBLE_MAYOR_ACUM_MIN_EN
    .acum_min      (acum_min),
`endif
    .acum_count    (acum_count),
    .acum_trunc    (acum_trunc),
    .acum_valid    (acum_valid),
    .acum_ready    (acum_ready),
    .acum_overflow (acum_overflow),
    .acum_clr_ovf  (acum_clr_ovf)
  );

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one beat (or idle cycle) from a negedge and returns at the next negedge.
  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic l);
    acum_in_valid = v;
    acum_in       = d;
    acum_in_last  = l;
    @(negedge CLK);
    acum_in_valid = 1'b0;
    acum_in_last  = 1'b0;
  endtask

  task automatic pushExp(input logic [3:0] mx, input logic [3:0] c, input logic t, input logic [3:0] mn);
    exp_t e;
    e.max = mx; e.cnt = c; e.trunc = t; e.min = mn;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      checkVal("valid", acum_valid, 1);
      checkVal("max", acum_max, e.max);
      checkVal("count", acum_count, e.cnt);
      checkVal("trunc", acum_trunc, e.trunc);
`ifdef NIBBLE_MAYOR_ACUM_MIN_EN
      checkVal("min", acum_min, e.min);
`endif
    end
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, "_max"}, acum_max, 0);
    checkVal({tag, "_count"}, acum_count, 0);
    checkVal({tag, "_trunc"}, acum_trunc, 0);
    checkVal({tag, "_valid"}, acum_valid, 0);
    checkVal({tag, "_ovf"}, acum_overflow, 0);
`ifdef NIBBLE_MAYOR_ACUM_MIN_EN
    checkVal({tag, "_min"}, acum_min, 0);
`endif
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge CLK);
    checkReset("reset");
    RESET_L = 1'b1;
    @(negedge CLK);

    // Frame 3,9,5(last)
    applyStimulus(1, 4'h3, 0);
    applyStimulus(1, 4'h9, 0);
    checkVal("open_frame_valid", acum_valid, 0);
    applyStimulus(1, 4'h5, 1);
    pushExp(4'h9, 4'd3, 0, 4'h3);
    checkOutput();
    applyStimulus(0, 4'h0, 0);
    checkVal("drain_valid", acum_valid, 0);

    // Force close at FRAME_LEN, then back-to-back single-beat frame
    for (int i = 0; i < 7; i++) applyStimulus(1, 4'h2, 0);
    applyStimulus(1, 4'hA, 0);
    pushExp(4'hA, 4'd8, 1, 4'h2);
    checkOutput();
    applyStimulus(1, 4'h1, 1);
    pushExp(4'h1, 4'd1, 0, 4'h1);
    checkOutput();
    applyStimulus(0, 4'h0, 0);
    checkVal("b2b_drain_valid", acum_valid, 0);

    // Overwrite while stalled, then clear overflow
    acum_ready = 1'b0;
    applyStimulus(1, 4'hF, 1);
    pushExp(4'hF, 4'd1, 0, 4'hF);
    checkOutput();
    checkVal("ovf_before", acum_overflow, 0);
    applyStimulus(0, 4'h0, 0);
    checkVal("stall_valid", acum_valid, 1);
    checkVal("stall_max", acum_max, 4'hF);
    applyStimulus(1, 4'h4, 1);
    pushExp(4'h4, 4'd1, 0, 4'h4);
    checkOutput();
    checkVal("ovf_set", acum_overflow, 1);
    acum_clr_ovf = 1'b1;
    @(negedge CLK);
    acum_clr_ovf = 1'b0;
    checkVal("ovf_cleared", acum_overflow, 0);
    checkVal("clr_keeps_valid", acum_valid, 1);
    acum_ready = 1'b1;
    applyStimulus(0, 4'h0, 0);
    checkVal("stall_drain_valid", acum_valid, 0);

    // Frame spanning idle gaps: 7, gap, E, gap, 3(last)
    applyStimulus(1, 4'h7, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 4'h0, 0);
      checkVal("gap_valid", acum_valid, 0);
      checkVal("gap_max", acum_max, 4'h4);
    end
    applyStimulus(1, 4'hE, 0);
    repeat (3) applyStimulus(0, 4'h0, 0);
    checkVal("gap2_max", acum_max, 4'h4);
    applyStimulus(1, 4'h3, 1);
    pushExp(4'hE, 4'd3, 0, 4'h3);
    checkOutput();
    applyStimulus(0, 4'h0, 0);

    // Mid-frame reset discards C,D
    applyStimulus(1, 4'hC, 0);
    applyStimulus(1, 4'hD, 0);
    RESET_L = 1'b0;
    #1;
    checkReset("midreset");
    @(negedge CLK);
    RESET_L = 1'b1;
    applyStimulus(0, 4'h0, 0);
    checkReset("post_reset");
    applyStimulus(1, 4'h1, 1);
    pushExp(4'h1, 4'd1, 0, 4'h1);
    checkOutput();
    applyStimulus(0, 4'h0, 0);

`ifdef NIBBLE_MAYOR_ACUM_MIN_EN
    // Frame 6,2,B(last) exercises the minimum
    applyStimulus(1, 4'h6, 0);
    applyStimulus(1, 4'h2, 0);
    applyStimulus(1, 4'hB, 1);
    pushExp(4'hB, 4'd3, 0, 4'h2);
    checkOutput();
    applyStimulus(0, 4'h0, 0);
`endif

    checkVal("sb_leftover", 8'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
